// File: rtl/spi_sram_dump_tx_pkg.sv
// spi_sram_dump_tx_pkg: shared defaults, FSM encoding and SPI mode constants
package spi_sram_dump_tx_pkg;
  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 8;
  localparam int CLK_DIV_DEF = 2;
  localparam logic [1:0] SPI_MODE = 2'd0;
  localparam logic SCLK_IDLE = SPI_MODE[1];
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WAIT   = 3'd2,
    S_LOAD   = 3'd3,
    S_SHIFT  = 3'd4,
    S_FINISH = 3'd5
  } state_t;
endpackage

// File: rtl/spi_sram_dump_tx_addr.sv
// sram_read_address_counter: sequential SRAM read address, init takes priority over inc
module sram_read_address_counter import spi_sram_dump_tx_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] address_o
);
  logic [ADDR_W-1:0] addr_q, addr_d;
  assign addr_d = init_i ? '0 : inc_i ? addr_q + 1'b1 : addr_q;
  assign address_o = addr_q;
  // address register, wraps modulo 2^ADDR_W
  always_ff @(posedge clk or posedge rst)
    if (rst) addr_q <= '0;
    else addr_q <= addr_d;
endmodule

// File: rtl/spi_sram_dump_tx.sv
// spi_sram_dump_tx: reads SRAM from address 0 upward and shifts each word out as an SPI mode-0 master
module spi_sram_dump_tx import spi_sram_dump_tx_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W:0]   length_i,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_rd_o,
  input  logic [DATA_W-1:0] sram_data_i,
  output logic              spi_sclk_o,
  output logic              spi_cs_n_o,
  output logic              spi_mosi_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = DATA_W > 1 ? $clog2(DATA_W) : 1;
  state_t state_q, state_d;
  logic [ADDR_W:0] rem_q, rem_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic rd_q, rd_d, sclk_q, sclk_d, cs_n_q, cs_n_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
  logic accept, addr_inc, div_end, bit_end;
  assign div_end = div_q == DIV_W'(CLK_DIV - 1);
  assign bit_end = bit_q == BIT_W'(DATA_W - 1);
  sram_read_address_counter #(.ADDR_W(ADDR_W)) u_addr (
    .clk(clk),
    .rst(rst),
    .init_i(accept),
    .inc_i(addr_inc),
    .address_o(sram_addr_o)
  );
  assign sram_rd_o = rd_q;
  assign spi_sclk_o = sclk_q;
  assign spi_cs_n_o = cs_n_q;
  assign spi_mosi_o = mosi_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  // control FSM: read/wait/load per word, then half-period timed shifting, then CS hold before done
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    div_d = div_q;
    bit_d = bit_q;
    shift_d = shift_q;
    rd_d = 1'b0;
    sclk_d = sclk_q;
    cs_n_d = cs_n_q;
    mosi_d = mosi_q;
    busy_d = busy_q;
    done_d = 1'b0;
    accept = 1'b0;
    addr_inc = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) begin
        accept = 1'b1;
        rem_d = length_i;
        busy_d = 1'b1;
        div_d = '0;
        state_d = length_i == '0 ? S_FINISH : S_READ;
      end
      S_READ: begin
        rd_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: state_d = S_LOAD;
      S_LOAD: begin
        shift_d = sram_data_i;
        mosi_d = sram_data_i[DATA_W-1];
        cs_n_d = 1'b0;
        addr_inc = 1'b1;
        rem_d = rem_q - 1'b1;
        div_d = '0;
        bit_d = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) begin
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            shift_d = shift_q << 1;
            mosi_d = shift_d[DATA_W-1];
            bit_d = bit_end ? '0 : bit_q + 1'b1;
            if (bit_end) state_d = rem_q != '0 ? S_READ : S_FINISH;
          end
        end
      end
      S_FINISH: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) begin
          cs_n_d = 1'b1;
          busy_d = 1'b0;
          done_d = 1'b1;
          mosi_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state and registered outputs; reset drops CS and aborts any transfer immediately
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      rem_q <= '0;
      div_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      rd_q <= 1'b0;
      sclk_q <= SCLK_IDLE;
      cs_n_q <= 1'b1;
      mosi_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      div_q <= div_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      rd_q <= rd_d;
      sclk_q <= sclk_d;
      cs_n_q <= cs_n_d;
      mosi_q <= mosi_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
endmodule

// File: tb/tb_spi_sram_dump_tx.sv
// tb_spi_sram_dump_tx: table-driven check of SPI SRAM dump at CLK_DIV 2, 1 and 4
module tb_spi_sram_dump_tx;
  typedef struct packed {
    int rises;
    int nrd;
    int dcnt;
    int csf;
    int tbad;
    logic [63:0] cap;
  } mon_t;
  typedef struct {
    int inst;
    int len;
    logic [7:0] w0, w1, w2;
    int rises;
    int lat;
    int nb;
    logic [23:0] bits;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] start = '0;
  logic [4:0] len [3];
  logic [3:0] addr [3];
  logic [2:0] rd, sclk, cs_n, mosi, busy, done;
  logic [7:0] mem [16];
  mon_t mon [3];
  int total = 0;
  int bad = 0;
  vec_t vecs [6];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_d
    localparam int CD = g == 0 ? 2 : g == 1 ? 1 : 4;
    logic [7:0] rdata = '0;
    logic [63:0] cap = '0;
    logic sclk_p = 1'b0, mosi_p = 1'b0, cs_p = 1'b1;
    logic [3:0] exp_a = '0;
    int rises = 0, nrd = 0, dcnt = 0, csf = 0, hb = 0, lb = 0, sb = 0, ob = 0;
    int nbit = 0, hi_run = 0, lo_run = 0;
    spi_sram_dump_tx #(.ADDR_W(4), .DATA_W(8), .CLK_DIV(CD)) dut (
      .clk(clk),
      .rst(rst),
      .start_i(start[g]),
      .length_i(len[g]),
      .sram_addr_o(addr[g]),
      .sram_rd_o(rd[g]),
      .sram_data_i(rdata),
      .spi_sclk_o(sclk[g]),
      .spi_cs_n_o(cs_n[g]),
      .spi_mosi_o(mosi[g]),
      .busy_o(busy[g]),
      .done_o(done[g])
    );
    always @(posedge clk) if (rd[g]) rdata <= mem[addr[g]];
    always @(negedge clk) begin
      sclk_p <= sclk[g];
      mosi_p <= mosi[g];
      cs_p <= cs_n[g];
      if (done[g]) dcnt <= dcnt + 1;
      if (!cs_n[g] && cs_p) csf <= csf + 1;
      if (rst) begin
        nbit <= 0;
        exp_a <= '0;
        hi_run <= 0;
        lo_run <= 0;
      end else begin
        if (rd[g]) begin
          nrd <= nrd + 1;
          if (addr[g] != exp_a) ob <= ob + 1;
          exp_a <= addr[g] + 4'd1;
        end
        if (done[g]) exp_a <= '0;
        if (sclk[g] && !sclk_p) begin
          rises <= rises + 1;
          cap <= {cap[62:0], mosi[g]};
          if (mosi[g] != mosi_p) sb <= sb + 1;
          if (nbit != 0 && lo_run != CD) lb <= lb + 1;
          nbit <= nbit == 7 ? 0 : nbit + 1;
        end
        if (!sclk[g] && sclk_p && hi_run != CD) hb <= hb + 1;
        hi_run <= sclk[g] ? (sclk_p ? hi_run + 1 : 1) : 0;
        lo_run <= sclk[g] ? lo_run : (sclk_p ? 1 : lo_run + 1);
      end
    end
    assign mon[g] = '{rises, nrd, dcnt, csf, hb + lb + sb + ob, cap};
  end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic run(input vec_t v);
    int g, lat;
    mon_t m0, m1;
    logic [63:0] mk;
    g = v.inst;
    mem[0] = v.w0;
    mem[1] = v.w1;
    mem[2] = v.w2;
    m0 = mon[g];
    len[g] = 5'(v.len);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    len[g] = 5'd7;
    chk("busy_after_start", 64'(busy[g]), 64'd1);
    lat = 0;
    while (!done[g] && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
    chk("done_latency", 64'(lat), 64'(v.lat));
    repeat (4) @(negedge clk);
    m1 = mon[g];
    chk("sclk_rises", 64'(m1.rises - m0.rises), 64'(v.rises));
    chk("sram_reads", 64'(m1.nrd - m0.nrd), 64'(v.len));
    chk("done_pulses", 64'(m1.dcnt - m0.dcnt), 64'd1);
    chk("cs_falls", 64'(m1.csf - m0.csf), v.len > 0 ? 64'd1 : 64'd0);
    chk("timing_order", 64'(m1.tbad - m0.tbad), 64'd0);
    if (v.nb > 0) begin
      mk = (64'd1 << v.nb) - 64'd1;
      chk("mosi_bits", m1.cap & mk, {40'd0, v.bits} & mk);
    end
    chk("idle_cs_busy_sclk", 64'({cs_n[g], busy[g], sclk[g]}), 64'b100);
  endtask
  initial begin
    int lat;
    mon_t m0, m1;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 13 + 7);
    for (int i = 0; i < 3; i++) len[i] = '0;
    vecs[0] = '{0, 1, 8'hA5, 8'h00, 8'h00, 8, 37, 8, 24'h0000A5};
    vecs[1] = '{0, 3, 8'h01, 8'h80, 8'hFF, 24, 107, 24, 24'h0180FF};
    vecs[2] = '{0, 0, 8'h11, 8'h22, 8'h33, 0, 2, 0, 24'h0};
    vecs[3] = '{1, 2, 8'h3C, 8'hC3, 8'h00, 16, 39, 16, 24'h003CC3};
    vecs[4] = '{2, 2, 8'h5A, 8'h96, 8'h00, 16, 138, 16, 24'h005A96};
    vecs[5] = '{0, 16, 8'h12, 8'h34, 8'h56, 128, 562, 16, 24'h00BDCA};
    repeat (3) @(negedge clk);
    chk("reset_values", 64'({addr[0], rd[0], sclk[0], cs_n[0], mosi[0], busy[0], done[0]}), 64'b0000_0_0_1_0_0_0);
    #2 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) run(vecs[i]);
    m0 = mon[0];
    mem[0] = 8'h01;
    mem[1] = 8'h80;
    mem[2] = 8'hFF;
    len[0] = 5'd3;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (20) @(negedge clk);
    chk("cs_low_before_rst", 64'(cs_n[0]), 64'd0);
    #2 rst = 1'b1;
    #1 chk("rst_async_outputs", 64'({cs_n[0], sclk[0], mosi[0], busy[0], done[0]}), 64'b10000);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (200) @(negedge clk);
    m1 = mon[0];
    chk("no_done_after_rst", 64'(m1.dcnt - m0.dcnt), 64'd0);
    chk("idle_after_rst", 64'({cs_n[0], busy[0]}), 64'b10);
    m0 = mon[0];
    mem[0] = 8'h5C;
    len[0] = 5'd1;
    start[0] = 1'b1;
    repeat (20) @(negedge clk);
    start[0] = 1'b0;
    repeat (5) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    lat = 0;
    while (!done[0] && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    chk("hold_done_seen", 64'(done[0]), 64'd1);
    repeat (60) @(negedge clk);
    m1 = mon[0];
    chk("hold_one_done", 64'(m1.dcnt - m0.dcnt), 64'd1);
    chk("hold_one_dump", 64'(m1.rises - m0.rises), 64'd8);
    chk("hold_bits", 64'(m1.cap[7:0]), 64'h5C);
    chk("hold_idle", 64'(busy[0]), 64'd0);
    run(vecs[0]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
